// File: rtl/mips_pkg.sv
// Shared types for the pipeline's memory arbiter: FSM states and transaction owner.
package mips_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  // Number of byte-offset bits dropped to form a word address.
  localparam int unsigned ARB_BYTE_OFS_W = 2;

endpackage

// File: rtl/arb_starve_ctr.sv
// Owner selection between fetch and data ports, with a saturating counter that
// bounds how many consecutive data grants may bypass a pending fetch.
module arb_starve_ctr
  import mips_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pick_en_i,
  input  logic       i_req_i,
  input  logic       d_req_i,
  output logic       grant_o,
  output arb_owner_t owner_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starved;

  always_comb begin
    starved = i_req_i && (cnt_q == CW'(STARVE_MAX));
    grant_o = pick_en_i && (i_req_i || d_req_i);
    owner_o = (d_req_i && !starved) ? OWN_D : OWN_I;

    cnt_d = cnt_q;
    if (pick_en_i) begin
      // Only data grants that bypass a waiting fetch count toward starvation.
      if (!i_req_i || owner_o == OWN_I) begin
        cnt_d = '0;
      end else if (cnt_q != CW'(STARVE_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and data ports,
// one outstanding transaction at a time, with data priority bounded by starvation.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          prot_err
);

  localparam logic [AW-1:0] WORD_MASK = ~AW'((1 << ARB_BYTE_OFS_W) - 1);

  arb_state_t    state_q;
  arb_owner_t    owner_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          i_ready_q;
  logic          d_ready_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          prot_err_q;

  logic          grant;
  arb_owner_t    owner_pick;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst_n     (reset),
    .pick_en_i (state_q == ARB_IDLE),
    .i_req_i   (i_req),
    .d_req_i   (d_req),
    .grant_o   (grant),
    .owner_o   (owner_pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;

      if (mem_rvalid && state_q != ARB_WAIT) begin
        prot_err_q <= 1'b1;
      end

      case (state_q)
        ARB_IDLE: begin
          if (grant) begin
            owner_q   <= owner_pick;
            mem_req_q <= 1'b1;
            state_q   <= ARB_REQ;
            if (owner_pick == OWN_D) begin
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr & WORD_MASK;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_addr & WORD_MASK;
              mem_wdata_q <= '0;
            end
          end
        end
        ARB_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // Response data lands directly in the owner's output register so the
          // ready pulse and its data appear together in the RESP cycle.
          if (mem_rvalid) begin
            state_q <= ARB_RESP;
            if (owner_q == OWN_D) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= mem_rdata;
            end else begin
              i_ready_q <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign prot_err  = prot_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard and corner sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata = '0;
  logic        prot_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .prot_err   (prot_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cap_t;

  logic [31:0] mem [bit [31:0]];
  cap_t        cap_q[$];
  cap_t        cap_tmp;
  int          gnt_wait = 0;
  int          rv_wait  = 1;
  int          age      = 0;
  int          rv_cnt   = 0;
  logic        rv_q     = 1'b0;
  logic [31:0] rd_pend  = '0;
  logic [31:0] rd_now;

  assign mem_gnt    = mem_req && (age >= gnt_wait);
  assign mem_rvalid = rv_q;

  always @(posedge clk) begin
    rv_q <= 1'b0;
    if (rv_cnt == 1) begin
      rv_q      <= 1'b1;
      mem_rdata <= rd_pend;
    end
    if (rv_cnt > 0) rv_cnt <= rv_cnt - 1;
    age <= (mem_req && !mem_gnt) ? age + 1 : 0;
    if (mem_req && mem_gnt) begin
      cap_tmp.we    = mem_we;
      cap_tmp.addr  = mem_addr;
      cap_tmp.wdata = mem_wdata;
      cap_q.push_back(cap_tmp);
      rd_now = '0;
      if (mem_we) mem[mem_addr] = mem_wdata;
      else if (mem.exists(mem_addr)) rd_now = mem[mem_addr];
      if (rv_wait <= 1) begin
        rv_q      <= 1'b1;
        mem_rdata <= rd_now;
      end else begin
        rv_cnt  <= rv_wait - 1;
        rd_pend <= rd_now;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];

  always @(negedge clk) begin
    if (reset) begin
      chk("ready_exclusive", {31'b0, i_ready & d_ready}, 32'h0);
      if (i_ready) begin
        if (i_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_ready_unexpected: got i_ready=1, expected 0");
        end else chk("i_rdata", i_rdata, i_exp.pop_front());
      end else chk("i_rdata_idle", i_rdata, 32'h0);
      if (d_ready) begin
        if (d_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_ready_unexpected: got d_ready=1, expected 0");
        end else chk("d_rdata", d_rdata, d_exp.pop_front());
      end else chk("d_rdata_idle", d_rdata, 32'h0);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_i(input logic [31:0] addr, input logic [31:0] exp, output int lat);
    i_exp.push_back(exp);
    i_addr = addr;
    i_req  = 1'b1;
    lat    = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (i_ready) begin lat = k; break; end
    end
    i_req = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL i_timeout: got no i_ready, expected one within 80 cycles");
    end
  endtask

  task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, output int lat);
    d_exp.push_back(exp);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    lat     = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (d_ready) begin lat = k; break; end
    end
    d_req = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL d_timeout: got no d_ready, expected one within 80 cycles");
    end
  endtask

  task automatic idle_gap();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          pre;
    logic [31:0] pre_val;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
    int          gw;
    int          rw;
  } vec_t;

  vec_t vt[6];

  logic [31:0] exp_seq[6];
  int          l1, l2, w;
  cap_t        c;

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h2008_000A, 32'h0000_0040, 32'h2008_000A, 0, 1};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0,         1'b1, 32'h1122_3344, 32'h0000_0100, 32'h1122_3344, 0, 1};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 32'h0,         32'h0000_0204, 32'h0,         1, 2};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0206, 32'h0,         1'b0, 32'h0,         32'h0000_0204, 32'hCAFE_F00D, 2, 3};
    vt[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 0, 4};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0002, 32'h1234_5678, 1'b1, 32'h0BAD_F00D, 32'h0000_0000, 32'h0BAD_F00D, 3, 1};

    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #10;
    chk("rst_mem_req",   {31'b0, mem_req},  32'h0);
    chk("rst_mem_we",    {31'b0, mem_we},   32'h0);
    chk("rst_mem_addr",  mem_addr,          32'h0);
    chk("rst_mem_wdata", mem_wdata,         32'h0);
    chk("rst_i_ready",   {31'b0, i_ready},  32'h0);
    chk("rst_d_ready",   {31'b0, d_ready},  32'h0);
    chk("rst_i_rdata",   i_rdata,           32'h0);
    chk("rst_d_rdata",   d_rdata,           32'h0);
    chk("rst_prot_err",  {31'b0, prot_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      idle_gap();
      cap_q.delete();
      gnt_wait = vt[v].gw;
      rv_wait  = vt[v].rw;
      if (vt[v].pre) mem[vt[v].exp_maddr] = vt[v].pre_val;
      if (vt[v].is_d) do_d(vt[v].we, vt[v].addr, vt[v].wdata, vt[v].exp_rdata, l1);
      else            do_i(vt[v].addr, vt[v].exp_rdata, l1);
      chk($sformatf("v%0d_latency", v), l1, 2 + vt[v].gw + vt[v].rw);
      chk($sformatf("v%0d_ntxn", v), cap_q.size(), 1);
      if (cap_q.size() > 0) begin
        c = cap_q.pop_front();
        chk($sformatf("v%0d_mem_addr", v), c.addr, vt[v].exp_maddr);
        chk($sformatf("v%0d_mem_we", v), {31'b0, c.we}, {31'b0, vt[v].we});
        if (vt[v].we) chk($sformatf("v%0d_mem_wdata", v), c.wdata, vt[v].wdata);
      end
    end
    gnt_wait = 0; rv_wait = 1;

    // fetch with exact cycle timing
    idle_gap();
    cap_q.delete();
    i_exp.push_back(32'h2008_000A);
    i_addr = 32'h40; i_req = 1'b1;
    @(posedge clk); #1;
    chk("t1_mem_req", {31'b0, mem_req}, 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    chk("t1_wait_mem_req", {31'b0, mem_req}, 32'h0);
    chk("t1_wait_i_ready", {31'b0, i_ready}, 32'h0);
    @(posedge clk); #1;
    chk("t1_i_ready", {31'b0, i_ready}, 32'h1);
    chk("t1_d_ready", {31'b0, d_ready}, 32'h0);
    i_req = 1'b0;

    // simultaneous requests: data first
    idle_gap();
    cap_q.delete();
    mem[32'h80] = 32'h0123_4567;
    fork
      do_i(32'h80, 32'h0123_4567, l1);
      do_d(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, l2);
    join
    chk("t2_d_latency", l2, 3);
    chk("t2_i_latency", l1, 7);
    chk("t2_ntxn", cap_q.size(), 2);
    if (cap_q.size() >= 2) begin
      chk("t2_first_we",    {31'b0, cap_q[0].we}, 32'h1);
      chk("t2_first_addr",  cap_q[0].addr,  32'h100);
      chk("t2_first_wdata", cap_q[0].wdata, 32'hDEAD_BEEF);
      chk("t2_second_we",   {31'b0, cap_q[1].we}, 32'h0);
      chk("t2_second_addr", cap_q[1].addr,  32'h80);
    end

    // starvation bound: D,D,D,D,I,D
    idle_gap();
    cap_q.delete();
    mem[32'h200] = 32'h0000_1234;
    fork
      do_i(32'h200, 32'h0000_1234, l1);
      begin
        for (int k = 0; k < 5; k++) do_d(1'b1, 32'h300 + 32'(4 * k), 32'h1000 + 32'(k), 32'h0, l2);
      end
    join
    exp_seq[0] = 32'h300; exp_seq[1] = 32'h304; exp_seq[2] = 32'h308;
    exp_seq[3] = 32'h30C; exp_seq[4] = 32'h200; exp_seq[5] = 32'h310;
    chk("t3_ntxn", cap_q.size(), 6);
    if (cap_q.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk($sformatf("t3_grant%0d_addr", k), cap_q[k].addr, exp_seq[k]);
    end

    // memory stalls grant for 5 cycles
    idle_gap();
    cap_q.delete();
    gnt_wait = 5;
    d_exp.push_back(32'h0);
    d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h5A5A_5A5A; d_req = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_c%0d_mem_req", k), {31'b0, mem_req}, 32'h1);
      chk($sformatf("t4_c%0d_mem_addr", k), mem_addr, 32'h400);
      chk($sformatf("t4_c%0d_mem_we", k), {31'b0, mem_we}, 32'h1);
      chk($sformatf("t4_c%0d_mem_wdata", k), mem_wdata, 32'h5A5A_5A5A);
      chk($sformatf("t4_c%0d_d_ready", k), {31'b0, d_ready}, 32'h0);
      @(posedge clk); #1;
    end
    w = -1;
    for (int k = 0; k < 20; k++) begin
      if (d_ready) begin w = k; break; end
      @(posedge clk); #1;
    end
    d_req = 1'b0;
    chk("t4_ready_after_gnt", w, 2);
    chk("t4_ntxn", cap_q.size(), 1);
    gnt_wait = 0;
    chk("pre_t5_prot_err", {31'b0, prot_err}, 32'h0);

    // reset during WAIT, then stray rvalid in IDLE
    idle_gap();
    rv_wait = 6;
    i_addr = 32'h40; i_req = 1'b1;
    @(posedge clk); #1;
    chk("t5_mem_req", {31'b0, mem_req}, 32'h1);
    @(posedge clk); #1;
    chk("t5_wait_mem_req", {31'b0, mem_req}, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_mem_req",  {31'b0, mem_req},  32'h0);
    chk("t5_rst_mem_addr", mem_addr,          32'h0);
    chk("t5_rst_i_ready",  {31'b0, i_ready},  32'h0);
    chk("t5_rst_d_ready",  {31'b0, d_ready},  32'h0);
    chk("t5_rst_prot_err", {31'b0, prot_err}, 32'h0);
    i_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t5_c%0d_i_ready", k), {31'b0, i_ready}, 32'h0);
    end
    chk("t5_prot_err", {31'b0, prot_err}, 32'h1);
    chk("t5_mem_req_idle", {31'b0, mem_req}, 32'h0);

    chk("i_exp_drained", i_exp.size(), 0);
    chk("d_exp_drained", d_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
